// File: rtl/video_timing_pkg.sv
// Shared types, standard mode constants and a width helper for the raster
// timing generator.
package video_timing_pkg;

  // 800x600 @ 60 Hz, 40 MHz pixel clock
  localparam int M800_H_TOTAL  = 1056;
  localparam int M800_H_SYNC   = 128;
  localparam int M800_H_BPORCH = 88;
  localparam int M800_H_RES    = 800;
  localparam int M800_V_TOTAL  = 628;
  localparam int M800_V_SYNC   = 4;
  localparam int M800_V_BPORCH = 23;
  localparam int M800_V_RES    = 600;
  localparam logic M800_HS_POL = 1'b1;
  localparam logic M800_VS_POL = 1'b1;

  // 1024x768 @ 60 Hz, 65 MHz pixel clock
  localparam int M1024_H_TOTAL  = 1344;
  localparam int M1024_H_SYNC   = 136;
  localparam int M1024_H_BPORCH = 160;
  localparam int M1024_H_RES    = 1024;
  localparam int M1024_V_TOTAL  = 806;
  localparam int M1024_V_SYNC   = 6;
  localparam int M1024_V_BPORCH = 29;
  localparam int M1024_V_RES    = 768;
  localparam logic M1024_HS_POL = 1'b0;
  localparam logic M1024_VS_POL = 1'b0;

  // 1280x720 @ 60 Hz, 74.25 MHz pixel clock
  localparam int M720_H_TOTAL  = 1650;
  localparam int M720_H_SYNC   = 40;
  localparam int M720_H_BPORCH = 220;
  localparam int M720_H_RES    = 1280;
  localparam int M720_V_TOTAL  = 750;
  localparam int M720_V_SYNC   = 5;
  localparam int M720_V_BPORCH = 20;
  localparam int M720_V_RES    = 720;
  localparam logic M720_HS_POL = 1'b1;
  localparam logic M720_VS_POL = 1'b1;

  // Raw (polarity-free) per-pixel flags carried down the display pipeline.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic win;
    logic sof;
  } sync_flags_t;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/video_timing_gen_sync_delay_line.sv
// Fixed-depth shift register with a synchronous clear that loads every stage
// with a parameterised idle vector.
module sync_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= RST_VAL;
      end
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: early frame-buffer read strobe plus HS/VS/DE,
// window coordinates and start-of-frame delayed to meet the read data.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_TOTAL  = M800_H_TOTAL,
  parameter int   H_SYNC   = M800_H_SYNC,
  parameter int   H_BPORCH = M800_H_BPORCH,
  parameter int   H_RES    = M800_H_RES,
  parameter int   V_TOTAL  = M800_V_TOTAL,
  parameter int   V_SYNC   = M800_V_SYNC,
  parameter int   V_BPORCH = M800_V_BPORCH,
  parameter int   V_RES    = M800_V_RES,
  parameter int   RD_HRES  = 640,
  parameter int   RD_VRES  = 480,
  parameter logic HS_POL   = M800_HS_POL,
  parameter logic VS_POL   = M800_VS_POL,
  parameter int   DELAY    = 5
) (
  input  logic                         iclk,
  input  logic                         irst,
  input  logic                         ien,
  output logic                         orden,
  output logic                         ohs,
  output logic                         ovs,
  output logic                         ode,
  output logic                         owin,
  output logic [width_of(RD_HRES)-1:0] ox,
  output logic [width_of(RD_VRES)-1:0] oy,
  output logic                         osof
);

  localparam int XW = width_of(RD_HRES);
  localparam int YW = width_of(RD_VRES);
  // One spare count so HA+H_RES == H_TOTAL still fits in the compare.
  localparam int HW = width_of(H_TOTAL + 1);
  localparam int VW = width_of(V_TOTAL + 1);
  localparam int HA = H_SYNC + H_BPORCH;
  localparam int VA = V_SYNC + V_BPORCH;
  localparam int HO = HA + (H_RES - RD_HRES) / 2;
  localparam int VO = VA + (V_RES - RD_VRES) / 2;
  localparam int PW = $bits(sync_flags_t) + XW + YW;

  if (RD_HRES > H_RES) begin : g_bad_rd_hres
    $error("video_timing_gen: RD_HRES exceeds H_RES");
  end
  if (RD_VRES > V_RES) begin : g_bad_rd_vres
    $error("video_timing_gen: RD_VRES exceeds V_RES");
  end
  if (H_SYNC + H_BPORCH + H_RES > H_TOTAL) begin : g_bad_h_total
    $error("video_timing_gen: horizontal timing exceeds H_TOTAL");
  end
  if (V_SYNC + V_BPORCH + V_RES > V_TOTAL) begin : g_bad_v_total
    $error("video_timing_gen: vertical timing exceeds V_TOTAL");
  end
  if (DELAY < 1) begin : g_bad_delay
    $error("video_timing_gen: DELAY must be at least 1");
  end

  logic          idle;
  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;
  logic          h_last;
  logic          v_last;

  // Disabled means parked at the origin with a flushed pipeline.
  assign idle   = irst || !ien;
  assign h_last = (h_cnt_reg == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt_reg == VW'(V_TOTAL - 1));

  always_ff @(posedge iclk) begin
    if (idle) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_last) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= v_last ? '0 : v_cnt_reg + VW'(1);
    end else begin
      h_cnt_reg <= h_cnt_reg + HW'(1);
    end
  end

  logic          h_act;
  logic          v_act;
  logic          h_in_win;
  logic          v_in_win;
  sync_flags_t   flags_a;
  logic [XW-1:0] x_a;
  logic [YW-1:0] y_a;

  assign h_act    = (h_cnt_reg >= HW'(HA)) && (h_cnt_reg < HW'(HA + H_RES));
  assign v_act    = (v_cnt_reg >= VW'(VA)) && (v_cnt_reg < VW'(VA + V_RES));
  assign h_in_win = (h_cnt_reg >= HW'(HO)) && (h_cnt_reg < HW'(HO + RD_HRES));
  assign v_in_win = (v_cnt_reg >= VW'(VO)) && (v_cnt_reg < VW'(VO + RD_VRES));

  always_comb begin
    flags_a     = '0;
    x_a         = '0;
    y_a         = '0;
    flags_a.hs  = (h_cnt_reg < HW'(H_SYNC));
    flags_a.vs  = (v_cnt_reg < VW'(V_SYNC));
    flags_a.de  = h_act && v_act;
    flags_a.win = h_in_win && v_in_win;
    flags_a.sof = (h_cnt_reg == HW'(HO)) && (v_cnt_reg == VW'(VO));
    if (flags_a.win) begin
      x_a = XW'(h_cnt_reg - HW'(HO));
      y_a = YW'(v_cnt_reg - VW'(VO));
    end
  end

  sync_flags_t   flags_reg;
  logic [XW-1:0] x_reg;
  logic [YW-1:0] y_reg;

  always_ff @(posedge iclk) begin
    if (idle) begin
      flags_reg <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
    end else begin
      flags_reg <= flags_a;
      x_reg     <= x_a;
      y_reg     <= y_a;
    end
  end

  // The read strobe leaves here; the memory latency is covered by the delay line.
  assign orden = flags_reg.win;

  logic [PW-1:0] pipe_in;
  logic [PW-1:0] pipe_out;
  sync_flags_t   flags_d;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;

  assign pipe_in = {flags_reg, x_reg, y_reg};

  sync_delay_line #(
    .WIDTH   (PW),
    .DEPTH   (DELAY),
    .RST_VAL ('0)
  ) u_delay (
    .clk  (iclk),
    .srst (idle),
    .din  (pipe_in),
    .dout (pipe_out)
  );

  assign {flags_d, x_d, y_d} = pipe_out;

  assign ohs  = flags_d.hs ? HS_POL : ~HS_POL;
  assign ovs  = flags_d.vs ? VS_POL : ~VS_POL;
  assign ode  = flags_d.de;
  assign owin = flags_d.win;
  assign osof = flags_d.sof;
  assign ox   = x_d;
  assign oy   = y_d;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: directed vector table on a small raster plus
// randomized enable/reset traffic checked against a frame-position model.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  typedef struct {
    int   ht, hsync, hbp, hres, vt, vsync, vbp, vres, rdh, rdv, dly;
    logic hpol, vpol;
  } cfg_t;

  typedef struct packed {
    logic        hs, vs, de, win, rden, sof;
    logic [31:0] x, y;
  } out_t;

  typedef struct {
    int   cyc;
    out_t exp;
  } vec_t;

  // Instance A: the small test mode.  Instance B: odd horizontal margin,
  // full-height window, inverted polarities, minimum delay.
  localparam int A_RDH = 6, A_RDV = 2, A_DLY = 2;
  localparam int B_RDH = 7, B_RDV = 4, B_DLY = 1;

  logic clk = 1'b0;
  logic irst = 1'b1;
  logic ien = 1'b0;
  always #5 clk = ~clk;

  logic a_rden, a_hs, a_vs, a_de, a_win, a_sof;
  logic [width_of(A_RDH)-1:0] a_x;
  logic [width_of(A_RDV)-1:0] a_y;
  logic b_rden, b_hs, b_vs, b_de, b_win, b_sof;
  logic [width_of(B_RDH)-1:0] b_x;
  logic [width_of(B_RDV)-1:0] b_y;

  video_timing_gen #(
    .H_TOTAL(20), .H_SYNC(2), .H_BPORCH(3), .H_RES(10),
    .V_TOTAL(8), .V_SYNC(1), .V_BPORCH(2), .V_RES(4),
    .RD_HRES(A_RDH), .RD_VRES(A_RDV), .HS_POL(1'b1), .VS_POL(1'b1), .DELAY(A_DLY)
  ) dut_a (
    .iclk(clk), .irst(irst), .ien(ien), .orden(a_rden), .ohs(a_hs), .ovs(a_vs),
    .ode(a_de), .owin(a_win), .ox(a_x), .oy(a_y), .osof(a_sof)
  );

  video_timing_gen #(
    .H_TOTAL(20), .H_SYNC(2), .H_BPORCH(3), .H_RES(10),
    .V_TOTAL(8), .V_SYNC(1), .V_BPORCH(2), .V_RES(4),
    .RD_HRES(B_RDH), .RD_VRES(B_RDV), .HS_POL(1'b0), .VS_POL(1'b0), .DELAY(B_DLY)
  ) dut_b (
    .iclk(clk), .irst(irst), .ien(ien), .orden(b_rden), .ohs(b_hs), .ovs(b_vs),
    .ode(b_de), .owin(b_win), .ox(b_x), .oy(b_y), .osof(b_sof)
  );

  cfg_t cfg [2];
  int   pos_m [2];
  bit   en_ring [2][16];
  int   pos_ring [2][16];
  int   edge_cnt = 16;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  vec_t vec [$];

  function automatic out_t idle_out(input cfg_t c);
    out_t o;
    o = '0;
    o.hs = ~c.hpol;
    o.vs = ~c.vpol;
    return o;
  endfunction

  // Outputs implied by a raster position, straight from the timing rules.
  function automatic out_t decode(input cfg_t c, input int p);
    out_t o;
    int h, v, ha, va, ho, vo;
    o  = '0;
    h  = p % c.ht;
    v  = p / c.ht;
    ha = c.hsync + c.hbp;
    va = c.vsync + c.vbp;
    ho = ha + (c.hres - c.rdh) / 2;
    vo = va + (c.vres - c.rdv) / 2;
    o.hs  = (h < c.hsync) ? c.hpol : ~c.hpol;
    o.vs  = (v < c.vsync) ? c.vpol : ~c.vpol;
    o.de  = (h >= ha && h < ha + c.hres && v >= va && v < va + c.vres);
    o.win = (h >= ho && h < ho + c.rdh && v >= vo && v < vo + c.rdv);
    o.sof = (h == ho && v == vo);
    o.x   = o.win ? 32'(h - ho) : 32'd0;
    o.y   = o.win ? 32'(v - vo) : 32'd0;
    return o;
  endfunction

  task automatic model_edge();
    bit en;
    en = !irst && ien;
    for (int k = 0; k < 2; k++) begin
      en_ring[k][edge_cnt % 16]  = en;
      pos_ring[k][edge_cnt % 16] = pos_m[k];
      pos_m[k] = en ? (pos_m[k] + 1) % (cfg[k].ht * cfg[k].vt) : 0;
    end
    edge_cnt++;
  endtask

  // Read strobe reflects the last edge; display outputs reflect the position
  // DELAY edges earlier, provided the run was not interrupted since.
  function automatic out_t expect_now(input int k);
    out_t o;
    int   e;
    bit   all_en;
    e = edge_cnt - 1;
    all_en = 1'b1;
    for (int j = 0; j <= cfg[k].dly; j++) begin
      if (!en_ring[k][(e - j) % 16]) all_en = 1'b0;
    end
    o = all_en ? decode(cfg[k], pos_ring[k][(e - cfg[k].dly) % 16]) : idle_out(cfg[k]);
    o.rden = en_ring[k][e % 16] ? decode(cfg[k], pos_ring[k][e % 16]).win : 1'b0;
    return o;
  endfunction

  function automatic out_t got_a();
    out_t o;
    o.hs = a_hs; o.vs = a_vs; o.de = a_de; o.win = a_win; o.rden = a_rden; o.sof = a_sof;
    o.x = 32'(a_x); o.y = 32'(a_y);
    return o;
  endfunction

  function automatic out_t got_b();
    out_t o;
    o.hs = b_hs; o.vs = b_vs; o.de = b_de; o.win = b_win; o.rden = b_rden; o.sof = b_sof;
    o.x = 32'(b_x); o.y = 32'(b_y);
    return o;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got hs=%b vs=%b de=%b win=%b rden=%b sof=%b x=%0d y=%0d required hs=%b vs=%b de=%b win=%b rden=%b sof=%b x=%0d y=%0d",
               name, cyc, got.hs, got.vs, got.de, got.win, got.rden, got.sof, got.x, got.y,
               exp.hs, exp.vs, exp.de, exp.win, exp.rden, exp.sof, exp.x, exp.y);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("model_a", got_a(), expect_now(0));
    check("model_b", got_b(), expect_now(1));
  endtask

  task automatic add_vec(input int c, input logic hs, input logic vs, input logic de,
                         input logic win, input logic rden, input logic sof,
                         input int x, input int y);
    vec_t v;
    v.cyc = c;
    v.exp.hs = hs; v.exp.vs = vs; v.exp.de = de; v.exp.win = win;
    v.exp.rden = rden; v.exp.sof = sof; v.exp.x = 32'(x); v.exp.y = 32'(y);
    vec.push_back(v);
  endtask

  initial begin
    int  seg_len;
    bit  found;

    cfg[0] = '{20, 2, 3, 10, 8, 1, 2, 4, A_RDH, A_RDV, A_DLY, 1'b1, 1'b1};
    cfg[1] = '{20, 2, 3, 10, 8, 1, 2, 4, B_RDH, B_RDV, B_DLY, 1'b0, 1'b0};
    pos_m[0] = 0;
    pos_m[1] = 0;

    //      cyc  hs vs de win rden sof x y   (cycle counted from ien rising)
    add_vec(2,   0, 0, 0, 0,  0,   0,  0, 0);
    add_vec(3,   1, 1, 0, 0,  0,   0,  0, 0);
    add_vec(4,   1, 1, 0, 0,  0,   0,  0, 0);
    add_vec(5,   0, 1, 0, 0,  0,   0,  0, 0);
    add_vec(22,  0, 1, 0, 0,  0,   0,  0, 0);
    add_vec(23,  1, 0, 0, 0,  0,   0,  0, 0);
    add_vec(67,  0, 0, 0, 0,  0,   0,  0, 0);
    add_vec(68,  0, 0, 1, 0,  0,   0,  0, 0);
    add_vec(77,  0, 0, 1, 0,  0,   0,  0, 0);
    add_vec(78,  0, 0, 0, 0,  0,   0,  0, 0);
    add_vec(87,  0, 0, 0, 0,  0,   0,  0, 0);
    add_vec(88,  0, 0, 1, 0,  1,   0,  0, 0);
    add_vec(90,  0, 0, 1, 1,  1,   1,  0, 0);
    add_vec(93,  0, 0, 1, 1,  1,   0,  3, 0);
    add_vec(94,  0, 0, 1, 1,  0,   0,  4, 0);
    add_vec(95,  0, 0, 1, 1,  0,   0,  5, 0);
    add_vec(96,  0, 0, 1, 0,  0,   0,  0, 0);
    add_vec(110, 0, 0, 1, 1,  1,   0,  0, 1);
    add_vec(130, 0, 0, 1, 0,  0,   0,  0, 0);
    add_vec(163, 1, 1, 0, 0,  0,   0,  0, 0);
    add_vec(250, 0, 0, 1, 1,  1,   1,  0, 0);
    add_vec(410, 0, 0, 1, 1,  1,   1,  0, 0);

    irst = 1'b1;
    ien  = 1'b0;
    repeat (5) step();
    irst = 1'b0;
    repeat (40) step();
    check("idle_a", got_a(), idle_out(cfg[0]));
    check("idle_b", got_b(), idle_out(cfg[1]));
    $display("reset/idle phase: 45 cycles");

    ien = 1'b1;
    cyc = 0;
    foreach (vec[i]) begin
      while (cyc < vec[i].cyc) step();
      check($sformatf("vec_cyc%0d", vec[i].cyc), got_a(), vec[i].exp);
      $display("vector cyc=%0d hs=%b vs=%b de=%b win=%b rden=%b sof=%b x=%0d y=%0d", vec[i].cyc,
               a_hs, a_vs, a_de, a_win, a_rden, a_sof, a_x, a_y);
    end

    ien = 1'b0;
    repeat (2) step();
    ien = 1'b1;
    cyc = 0;
    while (cyc < 85) step();
    ien = 1'b0;
    while (cyc < 88) step();
    check("abort_idle_a", got_a(), idle_out(cfg[0]));
    $display("abort at cyc=85: outputs idle by cyc=88");

    ien = 1'b1;
    cyc = 0;
    found = 1'b0;
    while (cyc < 400 && !found) begin
      step();
      if (a_sof === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL restart_sof got=none_within_400 required=90");
    end else if (cyc != 90) begin
      failures++;
      $display("FAIL restart_sof got=%0d required=90", cyc);
    end
    $display("restart: first osof after %0d cycles", cyc);

    for (int s = 0; s < 30; s++) begin
      seg_len = $urandom_range(20, 420);
      irst = ($urandom_range(0, 3) == 0);
      step();
      irst = 1'b0;
      ien  = 1'b1;
      for (int i = 0; i < seg_len; i++) begin
        irst = ($urandom_range(0, 199) == 0);
        step();
      end
      irst = 1'b0;
      ien  = 1'b0;
      repeat ($urandom_range(1, 3)) step();
      $display("random segment %0d len=%0d", s, seg_len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
